// File: rtl/rvv_alu_seq.sv
// Lane-ALU sequencer: walks every (element, chunk) pair of a vector op across
// up to 2^MAX_LANES_LOG lanes and merges lane results into the destination.
module rvv_alu_seq #(
  parameter int VLEN          = 128,
  parameter int LANE_WIDTH    = 3,
  parameter int MAX_LANES_LOG = 2
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start,
  input  logic [2:0]                          vsew,
  input  logic [9:0]                          vl,
  input  logic [1:0]                          nb_lanes,
  input  logic [VLEN-1:0]                     vd_old,
  input  logic [64*(2**MAX_LANES_LOG)-1:0]    lane_vd,
  output logic                                run,
  output logic [10*(2**MAX_LANES_LOG)-1:0]    lane_index,
  output logic [3:0]                          in_reg_offset,
  output logic [(2**MAX_LANES_LOG)-1:0]       lane_valid,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [VLEN-1:0]                     vd_out
);
  localparam int NL = 2**MAX_LANES_LOG;
  localparam int LW = 2**LANE_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [3:0]  sew_sh_q;
  logic [3:0]  c_last_q;
  logic [10:0] vl_eff_q;
  logic [1:0]  nbl_q;
  logic [10:0] elem_base;
  logic [3:0]  offset;

  logic [3:0]  sew_sh;
  logic [10:0] max_elem;
  logic [10:0] vl_eff;
  logic [10:0] lanes_l;
  logic        sew_small;
  logic [3:0]  c_last;
  logic [10:0] e;

  // Only the low LW bits of each lane result are consumed.
  logic unused_lane_vd;
  assign unused_lane_vd = ^lane_vd;

  always_comb begin
    sew_sh    = {1'b0, vsew} + 4'd3;
    max_elem  = 11'(VLEN >> sew_sh);
    vl_eff    = ({1'b0, vl} < max_elem) ? {1'b0, vl} : max_elem;
    sew_small = (sew_sh < 4'(LANE_WIDTH));
    c_last    = sew_small ? 4'd0 : 4'((1 << (sew_sh - 4'(LANE_WIDTH))) - 1);
    lanes_l   = 11'(1) << nbl_q;
  end

  assign run           = (state == RUN);
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  assign in_reg_offset = offset;

  // Invalid lanes report index 0 so downstream never sees a stale address.
  always_comb begin
    lane_valid = '0;
    lane_index = '0;
    e          = '0;
    for (int i = 0; i < NL; i++) begin
      e             = elem_base + 11'(i);
      lane_valid[i] = (state == RUN) && (11'(i) < lanes_l) && (e < vl_eff_q);
      if (lane_valid[i])
        lane_index[10*i +: 10] = 10'((16'(e) << sew_sh_q) + (16'(offset) << LANE_WIDTH));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sew_sh_q  <= '0;
      c_last_q  <= '0;
      vl_eff_q  <= '0;
      nbl_q     <= '0;
      elem_base <= '0;
      offset    <= '0;
      err       <= 1'b0;
      vd_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vd_out    <= vd_old;
            elem_base <= '0;
            offset    <= '0;
            sew_sh_q  <= sew_sh;
            c_last_q  <= c_last;
            vl_eff_q  <= vl_eff;
            nbl_q     <= nb_lanes;
            err       <= sew_small;
            state     <= (sew_small || (vl_eff == 11'd0)) ? DONE : RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NL; i++) begin
            if (lane_valid[i])
              vd_out[lane_index[10*i +: 10] +: LW] <= lane_vd[64*i +: LW];
          end
          // Chunks of one element must be back to back for lane carry chaining.
          if (offset < c_last_q) begin
            offset <= offset + 4'd1;
          end else begin
            offset    <= '0;
            elem_base <= elem_base + lanes_l;
            if ((elem_base + lanes_l) >= vl_eff_q)
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Randomised bench for rvv_alu_seq with a behavioural model of the op timeline.
module tb_rvv_alu_seq;
  localparam int VLEN = 128;
  localparam int NL   = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        vsew = '0;
  logic [9:0]        vl = '0;
  logic [1:0]        nb_lanes = '0;
  logic [VLEN-1:0]   vd_old = '0;
  logic [64*NL-1:0]  lane_vd;
  logic              run, busy, done, err;
  logic [10*NL-1:0]  lane_index;
  logic [3:0]        in_reg_offset;
  logic [NL-1:0]     lane_valid;
  logic [VLEN-1:0]   vd_out;

  logic              start2 = 1'b0;
  logic [2:0]        vsew2 = '0;
  logic [9:0]        vl2 = '0;
  logic [VLEN-1:0]   vd_old2 = '0;
  logic [64*NL-1:0]  lane_vd2 = '0;
  logic              run2, busy2, done2, err2;
  logic [10*NL-1:0]  lane_index2;
  logic [3:0]        in_reg_offset2;
  logic [NL-1:0]     lane_valid2;
  logic [VLEN-1:0]   vd_out2;

  always #5 clk = ~clk;

  rvv_alu_seq dut (
    .clk(clk), .resetn(resetn), .start(start), .vsew(vsew), .vl(vl),
    .nb_lanes(nb_lanes), .vd_old(vd_old), .lane_vd(lane_vd), .run(run),
    .lane_index(lane_index), .in_reg_offset(in_reg_offset),
    .lane_valid(lane_valid), .busy(busy), .done(done), .err(err),
    .vd_out(vd_out)
  );

  rvv_alu_seq #(.LANE_WIDTH(4)) dut_lw16 (
    .clk(clk), .resetn(resetn), .start(start2), .vsew(vsew2), .vl(vl2),
    .nb_lanes(2'd0), .vd_old(vd_old2), .lane_vd(lane_vd2), .run(run2),
    .lane_index(lane_index2), .in_reg_offset(in_reg_offset2),
    .lane_valid(lane_valid2), .busy(busy2), .done(done2), .err(err2),
    .vd_out(vd_out2)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane responder: mode 0 hashes position and lane, mode 1 returns 0x10+element,
  // mode 2 returns 0xA0+chunk. Upper 56 bits carry junk the DUT must ignore.
  int         mode = 0;
  logic [7:0] salt = '0;
  logic [55:0] junk = '0;

  always_comb begin
    lane_vd = '0;
    for (int i = 0; i < NL; i++) begin
      logic [9:0] idx;
      logic [7:0] r;
      idx = lane_index[10*i +: 10];
      case (mode)
        1:       r = 8'h10 + 8'(idx >> 3);
        2:       r = 8'hA0 + 8'(in_reg_offset);
        default: r = 8'(idx * 13 + i * 71) + salt;
      endcase
      lane_vd[64*i +: 64] = {junk, r};
    end
  end

  always @(negedge clk) junk <= {$urandom, 24'($urandom)};

  function automatic logic [7:0] exp_chunk(int md, int p, int ln, int el, int k);
    case (md)
      1:       return 8'h10 + 8'(el);
      2:       return 8'hA0 + 8'(k);
      default: return 8'(p * 13 + ln * 71) + salt;
    endcase
  endfunction

  // Model: phase 0 idle, 1 running (m_t = cycles elapsed), 2 done.
  int m_phase = 0, m_t = 0, m_runlen = 0, m_C = 1, m_L = 1, m_sew = 8, m_vleff = 0;
  logic [127:0] m_final = '0;
  logic         m_err = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_phase = 0; m_t = 0; m_final = '0; m_err = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_sew   = 8 << vsew;
        m_L     = 1 << nb_lanes;
        m_vleff = (int'(vl) < VLEN / m_sew) ? int'(vl) : VLEN / m_sew;
        m_err   = (m_sew < 8);
        m_C     = m_sew / 8;
        m_runlen = ((m_vleff + m_L - 1) / m_L) * m_C;
        m_final = vd_old;
        for (int el = 0; el < m_vleff; el++)
          for (int k = 0; k < m_C; k++)
            m_final[el*m_sew + k*8 +: 8] = exp_chunk(mode, el*m_sew + k*8, el % m_L, el, k);
        m_t = 0;
        m_phase = (m_err || m_vleff == 0) ? 2 : 1;
      end
    end else if (m_phase == 1) begin
      m_t++;
      if (m_t == m_runlen) m_phase = 2;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (resetn && chk_en) begin
      logic [NL-1:0]    ev;
      logic [10*NL-1:0] ei;
      logic [3:0]       eo;
      int step, k, el;
      ev = '0; ei = '0; eo = '0;
      if (m_phase == 1) begin
        step = m_t / m_C;
        k    = m_t % m_C;
        eo   = 4'(k);
        for (int i = 0; i < NL; i++) begin
          el = step * m_L + i;
          if (i < m_L && el < m_vleff) begin
            ev[i] = 1'b1;
            ei[10*i +: 10] = 10'(el * m_sew + k * 8);
          end
        end
      end
      check("run", run, m_phase == 1);
      check("busy", busy, m_phase == 1);
      check("done", done, m_phase == 2);
      check("err", err, m_err);
      check("in_reg_offset", in_reg_offset, eo);
      check("lane_valid", lane_valid, ev);
      check("lane_index", lane_index, ei);
      if (m_phase != 1) check("vd_out", vd_out, m_final);
    end
  end

  task automatic do_op(input logic [2:0] sw, input logic [9:0] v, input logic [1:0] nb,
                       input logic [127:0] old, input int md, output int runc, output int lat);
    logic got;
    @(negedge clk);
    vsew = sw; vl = v; nb_lanes = nb; vd_old = old; mode = md; salt = 8'($urandom); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    runc = 0; lat = 1; got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) runc++;
      lat++;
      // Stray starts and garbage operands while busy must be ignored.
      start    = ($urandom_range(0, 5) == 0);
      vsew     = 3'($urandom);
      vl       = 10'($urandom);
      nb_lanes = 2'($urandom_range(0, 2));
      vd_old   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", got, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, lat, cnt;
    logic [127:0] old;
    logic [2:0] sw;
    logic [9:0] v;

    #12;
    check("rst_run", run, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_lane_valid", lane_valid, '0);
    check("rst_lane_index", lane_index, '0);
    check("rst_offset", in_reg_offset, '0);
    check("rst_vd_out", vd_out, '0);
    @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;

    do_op(3'd0, 10'd16, 2'd2, {$urandom, $urandom, $urandom, $urandom}, 1, rc, lat);
    check("t1_run_cycles", rc, 4);
    check("t1_done_latency", lat, 5);
    check("t1_vd_out", vd_out, 128'h1F1E1D1C1B1A19181716151413121110);

    do_op(3'd2, 10'd4, 2'd0, {$urandom, $urandom, $urandom, $urandom}, 2, rc, lat);
    check("t2_run_cycles", rc, 16);
    check("t2_vd_out", vd_out, {4{32'hA3A2A1A0}});

    do_op(3'd0, 10'd5, 2'd2, {16{8'hFF}}, 0, rc, lat);
    check("t3_run_cycles", rc, 2);
    check("t3_tail", vd_out[127:40], {11{8'hFF}});

    old = {$urandom, $urandom, $urandom, $urandom};
    do_op(3'd0, 10'd0, 2'd1, old, 0, rc, lat);
    check("t4_vl0_run_cycles", rc, 0);
    check("t4_vl0_latency", lat, 1);
    check("t4_vl0_vd_out", vd_out, old);
    do_op(3'd3, 10'd8, 2'd0, {$urandom, $urandom, $urandom, $urandom}, 0, rc, lat);
    check("t4_clamp_run_cycles", rc, 16);

    // Narrow element on 16-bit lanes is rejected with err.
    @(negedge clk);
    old = {$urandom, $urandom, $urandom, $urandom};
    vsew2 = 3'd0; vl2 = 10'd4; vd_old2 = old; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t5_done", done2, 1'b1);
    check("t5_err", err2, 1'b1);
    check("t5_busy", busy2, 1'b0);
    check("t5_vd_out", vd_out2, old);
    @(negedge clk);
    check("t5_done_gone", done2, 1'b0);
    check("t5_err_sticky", err2, 1'b1);
    check("t5_no_run", run2, 1'b0);
    vsew2 = 3'd1; vl2 = 10'd3; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("t5_err_cleared", err2, 1'b0);
    cnt = 0;
    for (int c = 0; c < 20 && !done2; c++) begin
      if (busy2) cnt++;
      @(negedge clk);
    end
    check("t5_sew16_run_cycles", cnt, 3);
    check("t5_sew16_done", done2, 1'b1);

    // Reset in the third run cycle.
    @(negedge clk);
    vsew = 3'd0; vl = 10'd16; nb_lanes = 2'd0; mode = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_before", busy, 1'b1);
    #1 resetn = 1'b0;
    #1;
    check("t6_run", run, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_lane_valid", lane_valid, '0);
    check("t6_lane_index", lane_index, '0);
    check("t6_offset", in_reg_offset, '0);
    check("t6_vd_out", vd_out, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t6_no_done", done, 1'b0);
    end
    #2 resetn = 1'b1;

    for (int n = 0; n < 40; n++) begin
      sw = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 3));
      v  = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 24));
      do_op(sw, v, 2'($urandom_range(0, 2)), {$urandom, $urandom, $urandom, $urandom},
            0, rc, lat);
    end

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rvv_alu_seq.md
Name: rvv_alu_seq

Overview:
- Sequencer and writeback collector on the initiator side of the lane-ALU interface.
- On a start pulse it steps 2^nb_lanes lane ALUs through every (element, chunk) pair of a vector op. Per cycle it drives run, per-lane bit index and the shared in_reg_offset, captures each lane's chunk result, and merges it into a destination vector register.
- It sits between the vector decode/issue stage and the lane array.
- It signals completion with a one-cycle done pulse and holds the assembled result.

Parameters:
- VLEN, 128: vector register width in bits.
- LANE_WIDTH, 3: log2 of lane chunk width, so LW = 2^LANE_WIDTH bits (8..64).
- MAX_LANES_LOG, 2: log2 of the number of lane ALUs physically attached (max 4 lanes).

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- vsew  in  3  element width code, SEW = 8<<vsew; latched at start.
- vl  in  10  element count; latched at start.
- nb_lanes  in  2  log2 of lanes used; latched at start; must be <= MAX_LANES_LOG.
- vd_old  in  VLEN  previous destination contents; latched at start.
- lane_vd  in  64*2^MAX_LANES_LOG  per-lane ALU result, lane i at [64i +: 64]; low LW bits are used.
- run  out  1  lane enable.
- lane_index  out  10*2^MAX_LANES_LOG  per-lane bit index, lane i at [10i +: 10].
- in_reg_offset  out  4  chunk number within the current element, shared by all lanes.
- lane_valid  out  2^MAX_LANES_LOG  lane i holds a real element this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky until next start; set when SEW < LW.
- vd_out  out  VLEN  assembled result register.

Behaviour:
Reset (asynchronous, resetn low):
- State IDLE.
- run, busy, done, err all 0.
- lane_index 0, in_reg_offset 0, lane_valid 0, vd_out 0.
- Internal counters 0.

Derived quantities:
- C = SEW/LW chunks per element.
- L = 2^nb_lanes.
- vl_eff = min(vl, VLEN/SEW).

State machine:
- IDLE -> RUN on start, when vl_eff > 0 and SEW >= LW. On entry: vd_out <= vd_old, elem_base <= 0, offset <= 0, err <= 0.
- IDLE -> DONE on start when vl_eff == 0. No run cycle; vd_out <= vd_old.
- IDLE -> DONE on start when SEW < LW. err <= 1; vd_out <= vd_old.
- RUN: each cycle run = 1, in_reg_offset = offset.
  - For lane i: e = elem_base + i; lane_index[i] = e*SEW + offset*LW; lane_valid[i] = (i < L) && (e < vl_eff).
  - At the posedge ending the cycle, for each valid lane: vd_out[lane_index[i] +: LW] <= lane_vd[64i +: LW].
  - Invalid lanes write nothing (tail undisturbed). Invalid lanes' lane_index is forced to 0.
- Advance rule in RUN:
  - If offset < C-1: offset++.
  - Else offset <= 0, elem_base += L.
  - If elem_base + L >= vl_eff: go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. vd_out holds until the next start.

Timing:
- Carry chaining: offset must go 0..C-1 on consecutive cycles with no bubbles, because lanes register carry per cycle.
- RUN length is ceil(vl_eff/L)*C cycles.
- done rises the cycle after the last RUN cycle.
- busy = (state == RUN).

Control rules:
- start while in RUN or DONE is ignored. No queuing.
- Inputs other than start and lane_vd are don't-care outside the start cycle.
- Reset asserted mid-RUN aborts immediately to reset values. No done is issued.
- Index arithmetic is 10-bit unsigned. Because vl_eff is clamped, no valid index exceeds VLEN-LW.

Test Plan:
1. VLEN=128, LW=8, vsew=0, vl=16, nb_lanes=2; lane i returns 8'h10+e -> 4 RUN cycles, done in cycle 5, vd_out bytes 0..15 = 0x10..0x1F.
2. vsew=2, vl=4, nb_lanes=0; lane 0 returns chunk 0xA0+offset -> 16 RUN cycles, in_reg_offset sequence 0,1,2,3 repeated 4 times, each 32-bit element = 0xA3A2A1A0.
3. vsew=0, vl=5, nb_lanes=2, vd_old all 0xFF -> 2 steps; step 2 lane_valid=4'b0001; bytes 0..4 written, bytes 5..15 remain 0xFF.
4. vl=0 -> no run, done one cycle after start, vd_out = vd_old. vsew=3 with vl=8 clamps to 2 elements, so 16 RUN cycles with nb_lanes=0.
5. LANE_WIDTH=4 with vsew=0 -> err=1, done next cycle, no run.
6. resetn low in 3rd RUN cycle -> all outputs 0 at once, no done. start pulsed while busy -> ignored, cycle count unchanged.
